// File: rtl/i2c_pkg.sv
// Shared types for the I2C transaction sequencer: byte-engine opcodes,
// sequencer states and the address-byte R/W bit.
package i2c_pkg;

    typedef enum logic [2:0] {
        OP_START  = 3'd0,
        OP_RSTART = 3'd1,
        OP_WRITE  = 3'd2,
        OP_READ   = 3'd3,
        OP_STOP   = 3'd4
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_ADDR_W = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RSTART = 3'd4,
        ST_ADDR_R = 3'd5,
        ST_READ   = 3'd6,
        ST_STOP   = 3'd7
    } state_e;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
        return {addr, rw};
    endfunction

endpackage

// File: rtl/i2c_byte_counter.sv
// Remaining-beat counter: loads a byte count, decrements per completed beat
// (never below zero) and flags the empty and final-beat conditions.
module i2c_byte_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero,
    output logic         last
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins over decrement.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
    assign last = (count_q == W'(1));

endmodule

// File: rtl/i2c_transaction_sequencer.sv
// Walks one I2C transaction (write, write-read or read-only) through a byte
// engine, one command outstanding at a time, with sticky status and counters.
module i2c_transaction_sequencer
    import i2c_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             packet_type,
    input  logic             sr_enable,
    input  logic [6:0]       slave_addr,
    input  logic [LEN_W-1:0] read_length,
    input  logic [LEN_W-1:0] write_length,
    input  logic             bus_available,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [2:0]       cmd_op,
    output logic [7:0]       cmd_data,
    output logic             cmd_nack,
    input  logic             resp_valid,
    input  logic             resp_ack,
    input  logic [7:0]       resp_data,
    input  logic             arb_lost,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             slave_nack,
    output logic             arb_loss,
    output logic [LEN_W-1:0] bytes_read,
    output logic [LEN_W-1:0] bytes_written
);

    state_e           state_q, state_d;
    cmd_op_e          cmd_op_q, cmd_op_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             slave_nack_q, slave_nack_d, arb_loss_q, arb_loss_d;
    logic [LEN_W-1:0] bytes_read_q, bytes_read_d, bytes_written_q, bytes_written_d;
    logic             cmd_valid_q, cmd_valid_d, cmd_nack_q, cmd_nack_d;
    logic [7:0]       cmd_data_q, cmd_data_d, rx_data_q, rx_data_d;
    logic             tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d;
    logic             wait_q, wait_d, type_q, type_d, sr_q, sr_d;
    logic [6:0]       addr_q, addr_d;
    // rd_phase: the next START is followed by the read address.
    // restart: the current STOP is followed by a fresh START.
    logic             rd_phase_q, rd_phase_d, restart_q, restart_d;
    logic             wr_load_s, wr_dec_s, wr_zero_s, wr_last_s;
    logic             rd_load_s, rd_dec_s, rd_zero_s, rd_last_s;
    state_e           after_wr_state_s;
    logic             after_wr_restart_s;

    i2c_byte_counter #(.W(LEN_W)) u_wr_cnt (
        .clk(clk), .rst_n(reset), .load(wr_load_s), .load_val(write_length),
        .dec(wr_dec_s), .zero(wr_zero_s), .last(wr_last_s)
    );

    i2c_byte_counter #(.W(LEN_W)) u_rd_cnt (
        .clk(clk), .rst_n(reset), .load(rd_load_s), .load_val(read_length),
        .dec(rd_dec_s), .zero(rd_zero_s), .last(rd_last_s)
    );

    assign after_wr_state_s   = (type_q && sr_q) ? ST_RSTART : ST_STOP;
    assign after_wr_restart_s = type_q && !sr_q;

    // Sequencer next-state: accept, arbitration abort, issue, handshake, response.
    always_comb begin
        state_d = state_q;           cmd_op_d = cmd_op_q;
        busy_d = busy_q;             done_d = 1'b0;
        slave_nack_d = slave_nack_q; arb_loss_d = arb_loss_q;
        bytes_read_d = bytes_read_q; bytes_written_d = bytes_written_q;
        cmd_valid_d = cmd_valid_q;   cmd_nack_d = cmd_nack_q;
        cmd_data_d = cmd_data_q;     rx_data_d = rx_data_q;
        tx_ready_d = 1'b0;           rx_valid_d = 1'b0;
        wait_d = wait_q;             type_d = type_q;
        sr_d = sr_q;                 addr_d = addr_q;
        rd_phase_d = rd_phase_q;     restart_d = restart_q;
        wr_load_s = 1'b0; wr_dec_s = 1'b0; rd_load_s = 1'b0; rd_dec_s = 1'b0;

        if (state_q == ST_IDLE) begin
            if (start && bus_available) begin
                type_d = packet_type;  sr_d = sr_enable;  addr_d = slave_addr;
                rd_phase_d = packet_type && (write_length == '0);
                restart_d = 1'b0;      wr_load_s = 1'b1;  rd_load_s = 1'b1;
                bytes_read_d = '0;     bytes_written_d = '0;
                slave_nack_d = 1'b0;   arb_loss_d = 1'b0;
                busy_d = 1'b1;         wait_d = 1'b0;     cmd_valid_d = 1'b0;
                state_d = ST_START;
            end else begin
                busy_d = 1'b0;
            end
        end else if (arb_lost) begin
            arb_loss_d = 1'b1;  done_d = 1'b1;  busy_d = 1'b0;
            cmd_valid_d = 1'b0; wait_d = 1'b0;  state_d = ST_IDLE;
        end else if (!cmd_valid_q && !wait_q) begin
            cmd_nack_d = 1'b0;
            cmd_data_d = 8'h00;
            case (state_q)
                ST_START:  begin cmd_valid_d = 1'b1; cmd_op_d = OP_START;  end
                ST_RSTART: begin cmd_valid_d = 1'b1; cmd_op_d = OP_RSTART; end
                ST_STOP:   begin cmd_valid_d = 1'b1; cmd_op_d = OP_STOP;   end
                ST_ADDR_W: begin
                    cmd_valid_d = 1'b1; cmd_op_d = OP_WRITE;
                    cmd_data_d = addr_byte(addr_q, RW_WRITE);
                end
                ST_ADDR_R: begin
                    cmd_valid_d = 1'b1; cmd_op_d = OP_WRITE;
                    cmd_data_d = addr_byte(addr_q, RW_READ);
                end
                ST_WRITE: begin
                    if (tx_valid) begin
                        cmd_valid_d = 1'b1; cmd_op_d = OP_WRITE; cmd_data_d = tx_data;
                    end else begin
                        cmd_valid_d = 1'b0;
                    end
                end
                ST_READ: begin
                    cmd_valid_d = 1'b1; cmd_op_d = OP_READ; cmd_nack_d = rd_last_s;
                end
                default: cmd_valid_d = 1'b0;
            endcase
        end else if (cmd_valid_q) begin
            if (cmd_ready) begin
                cmd_valid_d = 1'b0;
                wait_d = 1'b1;
                tx_ready_d = (state_q == ST_WRITE);
            end else begin
                cmd_valid_d = 1'b1;
            end
        end else if (resp_valid) begin
            wait_d = 1'b0;
            case (state_q)
                ST_START:  state_d = rd_phase_q ? ST_ADDR_R : ST_ADDR_W;
                ST_RSTART: state_d = ST_ADDR_R;
                ST_ADDR_W: begin
                    if (!resp_ack) begin
                        slave_nack_d = 1'b1; state_d = ST_STOP;
                    end else if (wr_zero_s) begin
                        state_d = after_wr_state_s; restart_d = after_wr_restart_s;
                        rd_phase_d = type_q;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!resp_ack) begin
                        slave_nack_d = 1'b1; state_d = ST_STOP;
                    end else begin
                        bytes_written_d = (&bytes_written_q) ? bytes_written_q
                                                             : bytes_written_q + LEN_W'(1);
                        wr_dec_s = 1'b1;
                        if (wr_last_s) begin
                            state_d = after_wr_state_s; restart_d = after_wr_restart_s;
                            rd_phase_d = type_q;
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_ADDR_R: begin
                    if (!resp_ack) begin
                        slave_nack_d = 1'b1; state_d = ST_STOP;
                    end else begin
                        state_d = rd_zero_s ? ST_STOP : ST_READ;
                    end
                end
                ST_READ: begin
                    rx_valid_d = 1'b1; rx_data_d = resp_data; rd_dec_s = 1'b1;
                    bytes_read_d = (&bytes_read_q) ? bytes_read_q : bytes_read_q + LEN_W'(1);
                    state_d = rd_last_s ? ST_STOP : ST_READ;
                end
                ST_STOP: begin
                    if (restart_q) begin
                        restart_d = 1'b0; state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE; busy_d = 1'b0; done_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            wait_d = wait_q;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;     cmd_op_q <= OP_START;
            busy_q <= 1'b0;         done_q <= 1'b0;
            slave_nack_q <= 1'b0;   arb_loss_q <= 1'b0;
            bytes_read_q <= '0;     bytes_written_q <= '0;
            cmd_valid_q <= 1'b0;    cmd_nack_q <= 1'b0;
            cmd_data_q <= 8'h00;    rx_data_q <= 8'h00;
            tx_ready_q <= 1'b0;     rx_valid_q <= 1'b0;
            wait_q <= 1'b0;         type_q <= 1'b0;
            sr_q <= 1'b0;           addr_q <= 7'h00;
            rd_phase_q <= 1'b0;     restart_q <= 1'b0;
        end else begin
            state_q <= state_d;     cmd_op_q <= cmd_op_d;
            busy_q <= busy_d;       done_q <= done_d;
            slave_nack_q <= slave_nack_d; arb_loss_q <= arb_loss_d;
            bytes_read_q <= bytes_read_d; bytes_written_q <= bytes_written_d;
            cmd_valid_q <= cmd_valid_d;   cmd_nack_q <= cmd_nack_d;
            cmd_data_q <= cmd_data_d;     rx_data_q <= rx_data_d;
            tx_ready_q <= tx_ready_d;     rx_valid_q <= rx_valid_d;
            wait_q <= wait_d;       type_q <= type_d;
            sr_q <= sr_d;           addr_q <= addr_d;
            rd_phase_q <= rd_phase_d;     restart_q <= restart_d;
        end
    end

    assign cmd_op        = cmd_op_q;
    assign cmd_valid     = cmd_valid_q;
    assign cmd_data      = cmd_data_q;
    assign cmd_nack      = cmd_nack_q;
    assign tx_ready      = tx_ready_q;
    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign slave_nack    = slave_nack_q;
    assign arb_loss      = arb_loss_q;
    assign bytes_read    = bytes_read_q;
    assign bytes_written = bytes_written_q;

endmodule
